// File: rtl/apb_core_master_pkg.sv
// Shared constants for the APB core master: FSM encodings, default widths and
// the timeout counter width helper.
package apb_core_master_pkg;

    localparam int unsigned DEF_BUS_WIDTH  = 16;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam logic [15:0] DEF_ERR_DATA   = 16'hDEAD;

    typedef logic [1:0] apbm_state_t;

    localparam apbm_state_t APBM_IDLE   = 2'd0;
    localparam apbm_state_t APBM_SETUP  = 2'd1;
    localparam apbm_state_t APBM_ACCESS = 2'd2;
    localparam apbm_state_t APBM_DONE   = 2'd3;

    // At least one bit so a disabled timeout (limit 0) still elaborates.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Per-transfer ACCESS-cycle counter; flags the cycle in which the wait budget
// runs out. Saturates instead of wrapping when the timeout is disabled.
module apb_timeout_ctr
    import apb_core_master_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW    = ctr_width(LIMIT);
    localparam int unsigned LastVal = (LIMIT == 0) ? 0 : LIMIT - 1;
    localparam logic [CntW-1:0] Last = CntW'(LastVal);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT != 0) && (cnt_q == Last);

endmodule

// File: rtl/apb_core_master.sv
// Core load/store port to APB3 master bridge with a per-transfer PREADY
// timeout. PSEL is held for the whole transfer; all outputs are registered.
module apb_core_master
    import apb_core_master_pkg::*;
#(
    parameter int unsigned BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(DEF_ERR_DATA)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [BUS_WIDTH-1:0]  core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_ack,
    output logic                  core_err,
    output logic                  core_busy,
    output logic [BUS_WIDTH-1:0]  M_PADDR,
    output logic                  M_PWRITE,
    output logic                  M_PSELx,
    output logic                  M_PENABLE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY
);

    apbm_state_t           state_q, state_d;
    logic [BUS_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
    logic ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic ctr_clear, ctr_en, ctr_expired;

    apb_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (ctr_clear),
        .enable_i (ctr_en),
        .expired_o(ctr_expired)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        err_d     = err_q;
        busy_d    = busy_q;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            APBM_IDLE: begin
                if (core_req) begin
                    pwrite_d  = core_we;
                    paddr_d   = core_addr;
                    pwdata_d  = core_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = APBM_SETUP;
                end
            end
            APBM_SETUP: begin
                penable_d = 1'b1;
                ctr_clear = 1'b1;
                state_d   = APBM_ACCESS;
            end
            APBM_ACCESS: begin
                // PREADY takes priority over a timeout in the same cycle.
                if (M_PREADY || ctr_expired) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = 1'b1;
                    busy_d    = 1'b0;
                    err_d     = !M_PREADY;
                    if (pwrite_q) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = M_PREADY ? M_PRDATA : ERR_DATA;
                    end
                    state_d = APBM_DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            APBM_DONE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = APBM_IDLE;
            end
            default: state_d = APBM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= APBM_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign core_rdata = rdata_q;
    assign core_ack   = ack_q;
    assign core_err   = err_q;
    assign core_busy  = busy_q;
    assign M_PADDR    = paddr_q;
    assign M_PWRITE   = pwrite_q;
    assign M_PSELx    = psel_q;
    assign M_PENABLE  = penable_q;
    assign M_PWDATA   = pwdata_q;

endmodule
